// File: rtl/ctrl_porta.sv
// ctrl_porta -- elevator car door controller.
//
// Drives the door motor through the open/hold/close cycle, watches the
// fully-open / fully-closed sensors, reopens on request while closing,
// and latches a fault if a transition takes too long or the sensors
// contradict each other. A fault is cleared only by reset.
//
// Parameters
//   T_HOLD     cycles the door stays fully open before closing by itself
//   T_TIMEOUT  max cycles allowed for an open or close stroke
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   req_abrir      one-cycle open request from the car controller
//   openDoor       open/hold button (level)
//   closeDoor      close button (level)
//   spa            door-fully-open sensor
//   spf            door-fully-closed sensor
//   potencia       power good (0 = power loss)
//   motorPorta     motor command: 00 stop, 01 open, 10 close
//   porta_fechada  door closed and locked, car may move
//   falha          sticky door fault
module ctrl_porta #(
    parameter int T_HOLD    = 50,
    parameter int T_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_abrir,
    input  logic       openDoor,
    input  logic       closeDoor,
    input  logic       spa,
    input  logic       spf,
    input  logic       potencia,
    output logic [1:0] motorPorta,
    output logic       porta_fechada,
    output logic       falha
);

    typedef enum logic [2:0] {
        FECHADA  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTA   = 3'd2,
        FECHANDO = 3'd3,
        FALHA    = 3'd4
    } state_t;

    localparam logic [1:0] MOT_STOP  = 2'b00;
    localparam logic [1:0] MOT_OPEN  = 2'b01;
    localparam logic [1:0] MOT_CLOSE = 2'b10;

    // A counter that already holds LAST before an edge has seen its full
    // span once that edge is counted, so the decision is taken on LAST.
    localparam logic [7:0] TMO_LAST  = 8'(T_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(T_HOLD - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;
    logic [7:0] r_hold;
    logic [7:0] w_hold_next;
    logic [1:0] r_motor;
    logic [1:0] w_motor_next;
    logic [7:0] w_timer_inc;
    logic [7:0] w_hold_inc;

    // Saturating increments: the counters must never wrap back to zero.
    assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
    assign w_hold_inc  = (r_hold  == 8'hFF) ? r_hold  : r_hold  + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FECHADA;
            r_timer <= 8'd0;
            r_hold  <= 8'd0;
            r_motor <= MOT_STOP;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_hold  <= w_hold_next;
            r_motor <= w_motor_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_hold_next  = r_hold;
        w_motor_next = MOT_STOP;

        // Without power everything holds still; only the motor drops to stop.
        if (potencia) begin
            if (r_state != FALHA && spa && spf) begin
                // Both end-of-travel sensors at once cannot be a real door.
                w_state_next = FALHA;
            end else begin
                case (r_state)
                    FECHADA: begin
                        if (req_abrir || openDoor) begin
                            w_state_next = ABRINDO;
                            w_timer_next = 8'd0;
                        end
                    end
                    ABRINDO: begin
                        if (spa) begin
                            w_state_next = ABERTA;
                            w_hold_next  = 8'd0;
                        end else if (r_timer >= TMO_LAST) begin
                            w_state_next = FALHA;
                        end else begin
                            w_timer_next = w_timer_inc;
                        end
                    end
                    ABERTA: begin
                        // Holding the open button beats both the close
                        // button and the auto-close timer.
                        if (openDoor) begin
                            w_hold_next = 8'd0;
                        end else if (closeDoor || r_hold >= HOLD_LAST) begin
                            w_state_next = FECHANDO;
                            w_timer_next = 8'd0;
                        end else begin
                            w_hold_next = w_hold_inc;
                        end
                    end
                    FECHANDO: begin
                        // A reopen request wins even if the door just closed.
                        if (openDoor || req_abrir) begin
                            w_state_next = ABRINDO;
                            w_timer_next = 8'd0;
                        end else if (spf) begin
                            w_state_next = FECHADA;
                        end else if (r_timer >= TMO_LAST) begin
                            w_state_next = FALHA;
                        end else begin
                            w_timer_next = w_timer_inc;
                        end
                    end
                    FALHA: begin
                        w_state_next = FALHA;
                    end
                    default: begin
                        w_state_next = FALHA;
                    end
                endcase
            end

            // Motor register follows the state being entered at this edge.
            case (w_state_next)
                ABRINDO:  w_motor_next = MOT_OPEN;
                FECHANDO: w_motor_next = MOT_CLOSE;
                default:  w_motor_next = MOT_STOP;
            endcase
        end
    end

    assign motorPorta    = r_motor;
    assign falha         = (r_state == FALHA);
    // Locked only while actually seen closed, including during reset.
    assign porta_fechada = (r_state == FECHADA) && spf;

endmodule
